// File: rtl/regfile_wb_if.sv
// Bundle between writeback sources/decode and the register-file write arbiter.
// The arbiter takes the slave modport.
interface regfile_wb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREQ   = 3
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic                   wr_en;
  logic [ADDR_W-1:0]      wr_addr;
  logic [DATA_W-1:0]      wr_data;
  logic [2:0]             wr_src;
  logic                   mark_valid;
  logic [ADDR_W-1:0]      mark_addr;
  logic [(1<<ADDR_W)-1:0] busy;
  logic                   idle;

  modport master (
    output req_valid, req_addr, req_data, mark_valid, mark_addr,
    input  req_ready, wr_en, wr_addr, wr_data, wr_src, busy, idle
  );

  modport slave (
    input  req_valid, req_addr, req_data, mark_valid, mark_addr,
    output req_ready, wr_en, wr_addr, wr_data, wr_src, busy, idle
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates NREQ writeback sources onto the single register-file write port and keeps a RAW busy scoreboard.
// Define WB_RR_ARB_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREQ   = 3
) (
  input  logic         clk,
  input  logic         rst,
  regfile_wb_if.slave  bus
);
  localparam int NREG = 1 << ADDR_W;
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   grant;
  logic [2:0]        gidx;
  logic              gany;

  logic              wr_en_d,   wr_en_q;
  logic [ADDR_W-1:0] wr_addr_d, wr_addr_q;
  logic [DATA_W-1:0] wr_data_d, wr_data_q;
  logic [2:0]        wr_src_d,  wr_src_q;
  logic [NREG-1:0]   busy_d,    busy_q;

`ifdef WB_RR_ARB_EN
  logic [2:0]        ptr_d,     ptr_q;

  always_comb begin
    int cand;
    grant = '0;
    gidx  = '0;
    gany  = 1'b0;
    cand  = 0;
    // Scan from the pointer, wrapping modulo NREQ; first valid requester wins.
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!gany && bus.req_valid[IW'(cand)]) begin
        gany = 1'b1;
        gidx = 3'(cand);
      end
    end
    if (rst) gany = 1'b0;
    if (gany) grant = NREQ'(1) << gidx;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gany) ptr_d = (int'(gidx) == NREQ - 1) ? 3'd0 : gidx + 3'd1;
  end
`else
  always_comb begin
    grant = '0;
    gidx  = '0;
    gany  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gany && bus.req_valid[IW'(k)]) begin
        gany = 1'b1;
        gidx = 3'(k);
      end
    end
    if (rst) gany = 1'b0;
    if (gany) grant = NREQ'(1) << gidx;
  end
`endif

  always_comb begin
    wr_en_d   = gany;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_src_d  = wr_src_q;
    if (gany) begin
      wr_addr_d = bus.req_addr[gidx*ADDR_W +: ADDR_W];
      wr_data_d = bus.req_data[gidx*DATA_W +: DATA_W];
      wr_src_d  = gidx;
    end
    // Clear on retire first so a same-edge claim by a newer instruction wins.
    busy_d = busy_q;
    if (wr_en_q)        busy_d[wr_addr_q]     = 1'b0;
    if (bus.mark_valid) busy_d[bus.mark_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_src_q  <= '0;
      busy_q    <= '0;
`ifdef WB_RR_ARB_EN
      ptr_q     <= '0;
`endif
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_src_q  <= wr_src_d;
      busy_q    <= busy_d;
`ifdef WB_RR_ARB_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign bus.req_ready = grant;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.wr_src    = wr_src_q;
  assign bus.busy      = busy_q;
  assign bus.idle      = (busy_q == '0) && !wr_en_q && (bus.req_valid == '0);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reference model of grant/write/scoreboard plus literal spot checks.
module tb_regfile_wb_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREQ   = 3;
  localparam int NREG   = 1 << ADDR_W;

  logic clk;
  logic rst;

  regfile_wb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREQ(NREQ)) bus ();

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requester side stimulus
  logic [NREQ-1:0]   pend;
  logic [ADDR_W-1:0] ra [NREQ];
  logic [DATA_W-1:0] rd [NREQ];
  logic              mark_v;
  logic [ADDR_W-1:0] mark_a;
  logic [NREQ-1:0]   acc;

  assign bus.req_valid  = pend;
  assign bus.mark_valid = mark_v;
  assign bus.mark_addr  = mark_a;

  always_comb begin
    bus.req_addr = '0;
    bus.req_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_addr[i*ADDR_W +: ADDR_W] = ra[i];
      bus.req_data[i*DATA_W +: DATA_W] = rd[i];
    end
  end

  // Reference model
  int                m_ptr;
  logic              m_wr_en;
  logic [ADDR_W-1:0] m_wr_addr;
  logic [DATA_W-1:0] m_wr_data;
  logic [2:0]        m_wr_src;
  logic [NREG-1:0]   m_busy;
  logic [NREQ-1:0]   m_grant;
  int                gi;

  function automatic logic [NREQ-1:0] exp_grant(logic [NREQ-1:0] v, int p);
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   r;
    r   = '0;
    dbl = {v, v} >> p;
    for (int k = 0; k < NREQ; k++)
      if (dbl[k] && r == '0) r[(k + p) % NREQ] = 1'b1;
    return r;
  endfunction

  function automatic int idx_of(logic [NREQ-1:0] g);
    for (int k = 0; k < NREQ; k++)
      if (g[k]) return k;
    return 0;
  endfunction

  function automatic logic [NREG-1:0] bit_of(logic [ADDR_W-1:0] a);
    logic [NREG-1:0] one;
    one = 1;
    return one << a;
  endfunction

  assign m_grant = rst ? '0 : exp_grant(pend, m_ptr);
  assign gi      = idx_of(m_grant);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_wr_en   <= 1'b0;
      m_wr_addr <= '0;
      m_wr_data <= '0;
      m_wr_src  <= '0;
      m_busy    <= '0;
      m_ptr     <= 0;
    end else begin
      m_busy <= (m_busy & ~(m_wr_en ? bit_of(m_wr_addr) : '0)) | (mark_v ? bit_of(mark_a) : '0);
      if (m_grant != '0) begin
        m_wr_en   <= 1'b1;
        m_wr_addr <= ra[gi];
        m_wr_data <= rd[gi];
        m_wr_src  <= 3'(gi);
`ifdef WB_RR_ARB_EN
        m_ptr     <= (gi + 1) % NREQ;
`endif
      end else begin
        m_wr_en <= 1'b0;
      end
    end
  end

  int tests;
  int fails;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: compare all outputs against the model mid-cycle, then advance and retire accepted requests.
  task automatic step();
    @(negedge clk);
    chk("req_ready", 64'(bus.req_ready), 64'(m_grant));
    chk("wr_en",     64'(bus.wr_en),     64'(m_wr_en));
    chk("wr_addr",   64'(bus.wr_addr),   64'(m_wr_addr));
    chk("wr_data",   64'(bus.wr_data),   64'(m_wr_data));
    chk("wr_src",    64'(bus.wr_src),    64'(m_wr_src));
    chk("busy",      64'(bus.busy),      64'(m_busy));
    chk("idle",      64'(bus.idle),      64'((m_busy == '0) && !m_wr_en && (pend == '0)));
    acc = pend & bus.req_ready;
    @(posedge clk);
    #1;
    pend   = pend & ~acc;
    mark_v = 1'b0;
  endtask

  task automatic post(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    ra[i]   = a;
    rd[i]   = d;
    pend[i] = 1'b1;
  endtask

  task automatic mark(input logic [ADDR_W-1:0] a);
    mark_a = a;
    mark_v = 1'b1;
  endtask

  logic [NREQ-1:0] seq3 [3];
  logic [NREQ-1:0] seq4 [4];

  initial begin
    tests  = 0;
    fails  = 0;
    rst    = 1'b1;
    pend   = '1;
    mark_v = 1'b0;
    mark_a = '0;
    acc    = '0;
    for (int i = 0; i < NREQ; i++) begin
      ra[i] = ADDR_W'(10 + i);
      rd[i] = 32'h1000_0000 + DATA_W'(i);
    end

    // Reset with all requesters asserting
    step();
    step();
    chk("rst_ready", 64'(bus.req_ready), 64'(3'b000));
    chk("rst_wr_en", 64'(bus.wr_en), 64'(1'b0));
    chk("rst_busy",  64'(bus.busy), 64'(0));
    pend = '0;
    #1;
    chk("rst_idle", 64'(bus.idle), 64'(1'b1));
    rst = 1'b0;
    step();

    // Single write from the load port
    post(1, 5'd7, 32'hDEAD_BEEF);
    #1;
    chk("single_ready", 64'(bus.req_ready), 64'(3'b010));
    step();
    chk("single_wr_en", 64'(bus.wr_en),   64'(1'b1));
    chk("single_addr",  64'(bus.wr_addr), 64'(7));
    chk("single_data",  64'(bus.wr_data), 64'(32'hDEAD_BEEF));
    chk("single_src",   64'(bus.wr_src),  64'(1));
    step();
    chk("single_wr_off", 64'(bus.wr_en), 64'(1'b0));
    chk("single_hold",   64'(bus.wr_data), 64'(32'hDEAD_BEEF));

    // ALU write on its own (leaves a round-robin pointer at 1)
    post(0, 5'd1, 32'h0000_0011);
    step();
    step();

    // Three-way contention, each requester drops on grant
`ifdef WB_RR_ARB_EN
    seq3[0] = 3'b010; seq3[1] = 3'b100; seq3[2] = 3'b001;
`else
    seq3[0] = 3'b001; seq3[1] = 3'b010; seq3[2] = 3'b100;
`endif
    post(0, 5'd10, 32'hA0A0_0000);
    post(1, 5'd11, 32'hA1A1_1111);
    post(2, 5'd31, 32'hA2A2_2222);
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("contend_grant", 64'(bus.req_ready), 64'(seq3[j]));
      step();
    end
    chk("contend_last_src", 64'(bus.wr_src), 64'(idx_of(seq3[2])));
    step();

    // ALU and link continuously valid
`ifdef WB_RR_ARB_EN
    seq4[0] = 3'b100; seq4[1] = 3'b001; seq4[2] = 3'b100; seq4[3] = 3'b001;
`else
    seq4[0] = 3'b001; seq4[1] = 3'b001; seq4[2] = 3'b001; seq4[3] = 3'b001;
`endif
    pend = 3'b101;
    for (int j = 0; j < 4; j++) begin
      #1;
      chk("alt_grant", 64'(bus.req_ready), 64'(seq4[j]));
      step();
      pend = pend | 3'b101;
    end
    pend = '0;
    step();
    step();

    // Scoreboard set, clear on retire, and set-wins on a same-edge collision
    mark(5'd5);
    step();
    chk("sb_mark5", 64'(bus.busy[5]), 64'(1'b1));
    chk("sb_not_idle", 64'(bus.idle), 64'(1'b0));
    post(0, 5'd5, 32'h5555_5555);
    step();
    chk("sb_wr5", 64'(bus.wr_addr), 64'(5));
    step();
    chk("sb_clear5", 64'(bus.busy[5]), 64'(1'b0));
    post(0, 5'd9, 32'h9999_9999);
    step();
    mark(5'd9);
    step();
    chk("sb_setwins9", 64'(bus.busy[9]), 64'(1'b1));
    step();

    // Reset one cycle after accepting a write to r3
    mark(5'd3);
    step();
    post(0, 5'd3, 32'h3333_3333);
    step();
    chk("midrst_pre_wr", 64'(bus.wr_en), 64'(1'b1));
    rst = 1'b1;
    #1;
    chk("midrst_wr_en", 64'(bus.wr_en), 64'(1'b0));
    chk("midrst_busy",  64'(bus.busy), 64'(0));
    step();
    rst = 1'b0;
    step();
    step();
    chk("midrst_no_r3", 64'(bus.wr_en), 64'(1'b0));
    chk("midrst_busy3", 64'(bus.busy[3]), 64'(1'b0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
